// File: rtl/lane_slice_pipe_pkg.sv
// Shared lane helpers for the lane-slice pipeline: word width and the
// bit-level index maps used to reverse lanes and expand a lane mask.
package lane_pkg;

    // Word width for a given lane geometry.
    function automatic int unsigned word_width(input int unsigned lane_w,
                                               input int unsigned lanes);
        return lane_w * lanes;
    endfunction

    // Lane index that owns word bit b (drives the per-bit mask expansion).
    function automatic int unsigned lane_of(input int unsigned b,
                                            input int unsigned lane_w);
        return b / lane_w;
    endfunction

    // Source bit for output bit b when lanes are reversed:
    // out lane i takes in lane LANES-1-i, bit order inside a lane kept.
    function automatic int unsigned lane_reverse_src(input int unsigned b,
                                                     input int unsigned lane_w,
                                                     input int unsigned lanes);
        return (lanes - 1 - (b / lane_w)) * lane_w + (b % lane_w);
    endfunction

endpackage

// File: rtl/lane_slice_pipe_if.sv
// Bus bundle for lane_slice_pipe: input stream, config, output stream, count.
interface lane_slice_pipe_if
    import lane_pkg::*;
#(
    parameter int unsigned LANE_W = 4,
    parameter int unsigned LANES  = 4,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned W = word_width(LANE_W, LANES);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             cfg_load;
    logic [LANES-1:0] cfg_mask;
    logic             cfg_reverse;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_masked;
    logic [W-1:0]     out_lanes;
    logic [CNT_W-1:0] word_cnt;

    modport slave (
        input  in_valid, in_data, cfg_load, cfg_mask, cfg_reverse, out_ready,
        output in_ready, out_valid, out_masked, out_lanes, word_cnt
    );

    modport master (
        output in_valid, in_data, cfg_load, cfg_mask, cfg_reverse, out_ready,
        input  in_ready, out_valid, out_masked, out_lanes, word_cnt
    );
endinterface

// File: rtl/lane_slice_pipe_stage.sv
// One elastic register stage carrying a valid bit and two data words.
module lane_pipe_stage #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_masked,
    input  logic [W-1:0] in_lanes,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_masked,
    output logic [W-1:0] out_lanes
);
    logic advance;

    // Stage moves when it is empty or its content is being taken downstream.
    always_comb begin
        advance = !out_valid || out_ready;
    end

    // Stage register; data only reloads when a real word arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_masked <= '0;
            out_lanes  <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_masked <= in_masked;
                out_lanes  <= in_lanes;
            end
        end
    end
endmodule

// File: rtl/lane_slice_pipe.sv
// Elastic lane-slice pipeline: masks and optionally lane-reverses each word
// at capture, carries it through DEPTH stages and counts delivered words.
module lane_slice_pipe
    import lane_pkg::*;
#(
    parameter int unsigned LANE_W   = 4,
    parameter int unsigned LANES    = 4,
    parameter int unsigned DEPTH    = 2,
    parameter logic [LANES-1:0] MASK_RST = LANES'(1),
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    lane_slice_pipe_if.slave  bus
);
    localparam int unsigned W = word_width(LANE_W, LANES);

    logic [LANES-1:0] mask_r;
    logic             rev_r;
    logic [W-1:0]     mask_bits;
    logic [W-1:0]     rev_bits;
    logic [W-1:0]     s0_masked;
    logic [W-1:0]     s0_lanes;
    logic [DEPTH-1:0] stg_v;
    logic [W-1:0]     stg_m [DEPTH];
    logic [W-1:0]     stg_l [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [CNT_W-1:0] cnt_q;

    // Config registers; a word accepted on the load cycle still sees the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= MASK_RST;
            rev_r  <= 1'b0;
        end else if (bus.cfg_load) begin
            mask_r <= bus.cfg_mask;
            rev_r  <= bus.cfg_reverse;
        end
    end

    // Per-bit mask expansion and lane-reverse wiring, fixed at elaboration.
    for (genvar b = 0; b < W; b++) begin : g_bit
        localparam int unsigned SRC = lane_reverse_src(b, LANE_W, LANES);
        localparam int unsigned LN  = lane_of(b, LANE_W);
        assign rev_bits[b]  = bus.in_data[SRC];
        assign mask_bits[b] = mask_r[LN];
    end

    // Stage-0 transform binds the config current on the acceptance cycle.
    always_comb begin
        s0_masked = bus.in_data & ~mask_bits;
        s0_lanes  = rev_r ? rev_bits : bus.in_data;
    end

    // Ready chain in lookahead form: stage k can take a word if any stage
    // from k to the end is empty or the output is being drained. Computed
    // from the registered valids only, so the chain has no self-loop.
    always_comb begin
        logic run;
        run        = bus.out_ready;
        rdy[DEPTH] = bus.out_ready;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            run = run || !stg_v[DEPTH-1-i];
            rdy[DEPTH-1-i] = run;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic         v_in;
        logic [W-1:0] m_in;
        logic [W-1:0] l_in;

        if (k == 0) begin : g_head
            // First stage is fed by the transformed input word.
            always_comb begin
                v_in = bus.in_valid;
                m_in = s0_masked;
                l_in = s0_lanes;
            end
        end else begin : g_body
            // Later stages are fed by the previous stage.
            always_comb begin
                v_in = stg_v[k-1];
                m_in = stg_m[k-1];
                l_in = stg_l[k-1];
            end
        end

        lane_pipe_stage #(.W(W)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (v_in),
            .in_masked  (m_in),
            .in_lanes   (l_in),
            .out_ready  (rdy[k+1]),
            .out_valid  (stg_v[k]),
            .out_masked (stg_m[k]),
            .out_lanes  (stg_l[k])
        );
    end

    // Delivered-word counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stg_v[DEPTH-1] && bus.out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Bus outputs come straight from registers except in_ready.
    always_comb begin
        bus.in_ready   = rdy[0];
        bus.out_valid  = stg_v[DEPTH-1];
        bus.out_masked = stg_m[DEPTH-1];
        bus.out_lanes  = stg_l[DEPTH-1];
        bus.word_cnt   = cnt_q;
    end
endmodule

// File: tb/tb_lane_slice_pipe.sv
// Bench for lane_slice_pipe at default geometry, plus a CNT_W=4 twin sharing
// the same inputs to observe counter wrap.
module tb_lane_slice_pipe;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;

    lane_slice_pipe_if #(.LANE_W(4), .LANES(4), .CNT_W(16)) bus ();
    lane_slice_pipe_if #(.LANE_W(4), .LANES(4), .CNT_W(4))  bus2 ();

    lane_slice_pipe #(.LANE_W(4), .LANES(4), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
    lane_slice_pipe #(.LANE_W(4), .LANES(4), .DEPTH(DEPTH), .CNT_W(4)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave)
    );

    assign bus2.in_valid    = bus.in_valid;
    assign bus2.in_data     = bus.in_data;
    assign bus2.cfg_load    = bus.cfg_load;
    assign bus2.cfg_mask    = bus.cfg_mask;
    assign bus2.cfg_reverse = bus.cfg_reverse;
    assign bus2.out_ready   = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference transforms in plain nibble arithmetic.
    function automatic logic [15:0] m_mask(input logic [15:0] d, input logic [3:0] m);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++)
            if (m[i]) r = r & ~(16'h000F << (4 * i));
        return r;
    endfunction

    function automatic logic [15:0] m_rev(input logic [15:0] d);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 4; i++)
            r = r | (((d >> (4 * i)) & 16'h000F) << (4 * (3 - i)));
        return r;
    endfunction

    typedef struct {
        logic [15:0] mk;
        logic [15:0] ln;
        int          t;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  mmask = 4'b0001;
    logic        mrev  = 1'b0;
    int          mcnt  = 0;
    int          cyc   = 0;

    // Model and per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        logic exp_v;
        exp_t e;
        if (rst) begin
            q.delete();
            mcnt  = 0;
            mmask = 4'b0001;
            mrev  = 1'b0;
        end else begin
            exp_v = (q.size() != 0) && (cyc - q[0].t >= DEPTH);
            chk("out_valid", bus.out_valid, exp_v);
            if (exp_v) begin
                chk("out_masked", bus.out_masked, q[0].mk);
                chk("out_lanes", bus.out_lanes, q[0].ln);
            end
            chk("word_cnt", bus.word_cnt, mcnt % 65536);
            chk("word_cnt4", bus2.word_cnt, mcnt % 16);
            if (bus.out_ready) chk("in_ready_flow", bus.in_ready, 1);
            else               chk("in_ready_stall", bus.in_ready, q.size() < DEPTH);
            if (exp_v && bus.out_ready) begin
                void'(q.pop_front());
                mcnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                e.mk = m_mask(bus.in_data, mmask);
                e.ln = mrev ? m_rev(bus.in_data) : bus.in_data;
                e.t  = cyc;
                q.push_back(e);
            end
            if (bus.cfg_load) begin
                mmask = bus.cfg_mask;
                mrev  = bus.cfg_reverse;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, bus.out_valid, 1);
    endtask

    task automatic load_cfg(input logic [3:0] m, input logic r);
        bus.cfg_load = 1'b1;
        bus.cfg_mask = m;
        bus.cfg_reverse = r;
        tick();
        bus.cfg_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [15:0] d;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 16'h0000;
        bus.cfg_load = 1'b0;
        bus.cfg_mask = 4'b0000;
        bus.cfg_reverse = 1'b0;
        bus.out_ready = 1'b1;

        // Model pins
        chk("model_mask", m_mask(16'hABCD, 4'b0001), 16'hABC0);
        chk("model_rev", m_rev(16'h1234), 16'h4321);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_masked", bus.out_masked, 16'h0000);
        chk("rst_out_lanes", bus.out_lanes, 16'h0000);
        chk("rst_word_cnt", bus.word_cnt, 0);

        // Test 1: default mask, latency of DEPTH
        tick();
        bus.in_valid = 1'b1;
        bus.in_data = 16'hABCD;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_not_yet", bus.out_valid, 0);
        @(negedge clk);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_masked", bus.out_masked, 16'hABC0);
        chk("t1_lanes", bus.out_lanes, 16'hABCD);
        @(negedge clk);
        chk("t1_cnt", bus.word_cnt, 1);

        // Test 2: mask 1010, reversed
        tick();
        load_cfg(4'b1010, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data = 16'h1234;
        tick();
        bus.in_valid = 1'b0;
        wait_out("t2");
        chk("t2_masked", bus.out_masked, 16'h0204);
        chk("t2_lanes", bus.out_lanes, 16'h4321);

        // Test 3: back-to-back stream, config change on 4th acceptance
        tick();
        load_cfg(4'b0001, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 16'(i);
            bus.cfg_load = (i == 4);
            bus.cfg_mask = 4'b0000;
            bus.cfg_reverse = 1'b0;
            tick();
            bus.cfg_load = 1'b0;
        end
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t3_cnt", bus.word_cnt, 10);

        // Test 4: stall fills DEPTH words, then release
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        d = 16'h0011;
        bus.in_data = d;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.in_ready) acc++;
            tick();
            bus.in_data = 16'h0011 + 16'(acc);
        end
        chk("t4_accepted", acc, 2);
        @(negedge clk);
        chk("t4_in_ready_low", bus.in_ready, 0);
        chk("t4_hold_masked", bus.out_masked, 16'h0011);
        tick();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 5; c++) begin
            @(negedge clk);
            if (bus.in_ready) acc++;
            tick();
            bus.in_data = 16'h0011 + 16'(acc);
            if (acc == 5) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("t4_total", acc, 5);
        repeat (5) @(negedge clk);
        chk("t4_cnt", bus.word_cnt, 15);

        // Mask all ones with reverse
        tick();
        load_cfg(4'b1111, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data = 16'h5A3C;
        tick();
        bus.in_valid = 1'b0;
        wait_out("allmask");
        chk("allmask_masked", bus.out_masked, 16'h0000);
        chk("allmask_lanes", bus.out_lanes, 16'hC3A5);
        repeat (3) @(negedge clk);

        // Test 5: reset with two words in flight
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 16'h00AA;
        tick();
        bus.in_data = 16'h00BB;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_cnt", bus.word_cnt, 0);
        chk("t5_masked", bus.out_masked, 16'h0000);
        tick();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 16'hFFFF;
        tick();
        bus.in_valid = 1'b0;
        wait_out("t5");
        chk("t5_rst_mask", bus.out_masked, 16'hFFF0);
        chk("t5_rst_rev", bus.out_lanes, 16'hFFFF);

        // Test 6: 17 deliveries since reset wraps the 4-bit counter to 1
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 16'(i * 16'h0123);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_cnt16", bus.word_cnt, 17);
        chk("t6_cnt4", bus2.word_cnt, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
